// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store path. This package holds the RISC-V
// memory funct3 codes, the LSU state enum, and small decode helpers for access
// size and funct3 legality.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    SECOND
  } lsu_state_t;

  // Access size in bytes. Code 11 is illegal and is caught by the fault logic.
  // Word size is returned for it so that the value is always defined.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we)
      return funct3 inside {F3_B, F3_H, F3_W};
    else
      return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// This interface bundles the core request/response signals and the data
// memory port of the load/store unit.
//   req_*      : memory instruction from the execute stage
//   stall/done : handshake back to the core; fault reports a rejected access
//   load_data  : extended load result
//   mem_*      : word-organised data memory port. Reads are combinational.
//   slave  modport : the LSU itself
//   master modport : the core plus the data memory around it
// -----------------------------------------------------------------------------
interface load_store_unit_if;

  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output stall, done, load_data, fault, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  stall, done, load_data, fault, mem_addr, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
// This is the purely combinational byte steering block for the LSU.
//   word       : current memory word (mem_rdata)
//   offset     : byte offset of the access inside word A
//   size       : access size in bytes (1, 2 or 4)
//   data       : store data (rs2)
//   second     : 1 while the second word (A+1) of a split access is addressed
//   hold       : bytes off..3 of word A, shifted down to bit 0
//   zero_ext   : 1 for LBU/LHU
//   store_word : word with the addressed bytes replaced, for read-modify-write
//   load_value : extracted and extended load result
// -----------------------------------------------------------------------------
module lsu_byte_lane (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic [31:0] data,
  input  logic        second,
  input  logic [31:0] hold,
  input  logic        zero_ext,
  output logic [31:0] store_word,
  output logic [31:0] load_value
);

  logic [3:0]  lo;
  logic [3:0]  hi;
  logic [3:0]  pos;
  logic [3:0]  rel;
  logic [31:0] raw;

  assign lo = {2'b00, offset};
  assign hi = lo + {1'b0, size};

  // Byte positions are counted across the two-word window {A+1, A}.
  // Byte i of the current word sits at position i, or at i+4 in the
  // second cycle. A position in [off, off+n) takes data byte (pos - off).
  always_comb begin
    store_word = word;
    pos        = '0;
    rel        = '0;
    for (int i = 0; i < 4; i++) begin
      pos = {1'b0, second, 2'(i)};
      rel = pos - lo;
      if (pos >= lo && pos < hi)
        store_word[8*i +: 8] = data[8*rel[1:0] +: 8];
    end
  end

  // In the second cycle the low bytes of word A+1 are stacked above the held
  // bytes of word A. The size mask below drops any bytes beyond n.
  always_comb begin
    if (second)
      raw = hold | (word << (6'd32 - {1'b0, offset, 3'b000}));
    else
      raw = word >> {offset, 3'b000};

    case (size)
      3'd1:    load_value = zero_ext ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      3'd2:    load_value = zero_ext ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: load_value = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// This block sits between the execute stage and a word-organised data memory.
// It adds byte, halfword and word accesses, sign and zero extension, and
// misaligned access splitting. Sub-word stores use read-modify-write. An access
// that straddles two words takes two cycles while the core is stalled.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : core request/response and data memory port (slave modport)
//   split_cnt  : saturating count of completed split accesses
// -----------------------------------------------------------------------------
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus,
  output logic [CNT_W-1:0]   split_cnt
);

  lsu_state_t  state_q;
  lsu_state_t  state_d;
  logic [31:0] hold_q;

  logic [1:0]  off;
  logic [2:0]  size;
  logic [31:0] addr_a;
  logic [31:0] addr_b;
  logic        is_split;
  logic        out_of_range;
  logic        req_fault;
  logic        in_second;
  logic [31:0] lane_store;
  logic [31:0] lane_load;

  assign off          = bus.req_addr[1:0];
  assign size         = access_size(bus.req_funct3);
  assign addr_a       = {2'b00, bus.req_addr[31:2]};
  assign addr_b       = addr_a + 32'd1;
  assign is_split     = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign out_of_range = (addr_a >= 32'(MEM_WORDS)) ||
                        (is_split && addr_b >= 32'(MEM_WORDS));
  assign req_fault    = !funct3_legal(bus.req_we, bus.req_funct3) || out_of_range;
  assign in_second    = (state_q == SECOND);

  lsu_byte_lane u_lane (
    .word       (bus.mem_rdata),
    .offset     (off),
    .size       (size),
    .data       (bus.req_wdata),
    .second     (in_second),
    .hold       (hold_q),
    .zero_ext   (bus.req_funct3[2]),
    .store_word (lane_store),
    .load_value (lane_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // The FSM stays in SECOND for exactly one cycle. That cycle either finishes
  // the access or, with req_valid low, abandons it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.req_valid && !req_fault && is_split) state_d = SECOND;
      SECOND: state_d = IDLE;
    endcase
  end

  // Faults are only decoded in IDLE. The core holds the request stable during
  // a split, so a request that reached SECOND was already found legal.
  always_comb begin
    bus.stall     = 1'b0;
    bus.done      = 1'b0;
    bus.fault     = 1'b0;
    bus.load_data = '0;
    bus.mem_addr  = addr_a;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wdata = lane_store;
    if (bus.req_valid) begin
      if (in_second) begin
        bus.mem_addr  = addr_b;
        bus.mem_read  = 1'b1;
        bus.mem_write = bus.req_we;
        bus.done      = 1'b1;
        bus.load_data = bus.req_we ? 32'h0 : lane_load;
      end else if (req_fault) begin
        bus.done  = 1'b1;
        bus.fault = 1'b1;
      end else begin
        bus.mem_read  = 1'b1;
        bus.mem_write = bus.req_we;
        if (is_split) begin
          bus.stall = 1'b1;
        end else begin
          bus.done      = 1'b1;
          bus.load_data = bus.req_we ? 32'h0 : lane_load;
        end
      end
    end
  end

  // hold_q keeps bytes off..3 of word A, shifted down to bit 0, for a split
  // load. split_cnt counts on the edge that ends a completed SECOND cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      split_cnt <= '0;
    end else begin
      if (!in_second && state_d == SECOND && !bus.req_we)
        hold_q <= bus.mem_rdata >> {off, 3'b000};
      if (in_second && bus.req_valid && split_cnt != '1)
        split_cnt <= split_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end between the core's execute stage and the word-organised data memory. The data memory stores whole 32-bit words, reads combinationally and writes on the rising clock edge. This block adds byte, halfword and word accesses, sign/zero extension and misaligned-access splitting. Sub-word stores use read-modify-write, and an access that straddles two words is split over two cycles while the core is stalled.

## Interface
- MEM_WORDS, 64, data memory depth in 32-bit words
- CNT_W, 16, width of the split-access counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  memory instruction present this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold PC and request; access not finished
- done  out  1  access completes this cycle
- load_data  out  32  extended load result, valid when done && !req_we
- fault  out  1  with done: illegal funct3 or out-of-range word
- split_cnt  out  CNT_W  saturating count of split accesses
- mem_addr  out  32  word index into the data memory
- mem_read  out  1  data memory read enable
- mem_write  out  1  data memory write enable
- mem_wdata  out  32  merged word to write
- mem_rdata  in  32  combinational read data from the data memory

## Operation
- Size: n = 1 for funct3 x00, 2 for x01, 4 for 010.
- Offset: off = req_addr[1:0].
- Word A: A = req_addr[31:2].
- Split condition: off + n > 4.
- Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Any other code is illegal.
- Fault condition: illegal code, or A >= MEM_WORDS, or (split and A+1 >= MEM_WORDS).
- On fault:
  - done = 1, fault = 1, stall = 0.
  - mem_write = 0, load_data = 0.
  - No state change.
- Byte order is little-endian. Byte k of a word is bits [8k+7:8k].
- Loads: extract n bytes starting at off. Sign-extend for 000/001; zero-extend for 100/101.
- Stores: mem_read = 1 and mem_write = 1 in the same cycle. mem_wdata = mem_rdata with the addressed bytes replaced by the low bytes of req_wdata. All other bytes are preserved.
- FSM states: IDLE, SECOND.
  - IDLE, idle or aligned request: no state change. An aligned request completes in one cycle (done = 1, stall = 0).
  - IDLE, legal split request: access word A and set stall = 1.
    - Load: latch bytes off..3 of mem_rdata into hold_q.
    - Store: write word A with bytes off..3 taken from the low (4 − off) bytes of req_wdata.
    - Go to SECOND.
  - SECOND: access word A+1 with done = 1, stall = 0.
    - Load: bytes 0..(off+n−5) are combined with hold_q, then extended.
    - Store: write the remaining high bytes into bytes 0..(off+n−5).
    - Increment split_cnt (saturate at all-ones). Go to IDLE.
  - SECOND with req_valid = 0: abort. No memory access, done = 0, go to IDLE. Word A stays written, no split_cnt increment.
- When req_valid = 0 in IDLE: mem_read = 0, mem_write = 0, done = 0, stall = 0, load_data = 0.
- The core holds req_* stable while stall = 1.

## Timing
- Reset values: state = IDLE, hold_q = 0, split_cnt = 0. stall, done, fault, mem_read, mem_write and load_data are all 0 with req_valid low.
- Aligned or faulting access: 0-cycle latency. Outputs are combinational from req_*, mem_rdata and state. A store takes effect at the next rising edge.
- Split access: 2 cycles. stall is high in cycle 1 only; done is high in cycle 2 only.
- Reset asserted in SECOND: return to IDLE immediately and clear hold_q. Word A stays written; the second write is never issued.
- split_cnt updates on the edge that ends the SECOND cycle.

## Structure
- Shared package riscv_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the LSU state enum {IDLE, SECOND}
- Sub-module lsu_byte_lane is purely combinational. Given word, offset, size and data, it produces the merged store word and the extracted/extended load value. It is instantiated once.
- The FSM, hold_q, split_cnt and fault logic live in load_store_unit.

## Test plan
- SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> mem word 4 = 0xDEADBEEF; load_data = 0xDEADBEEF, done in 1 cycle, stall never high.
- Word 4 = 0x11223344; SB 0xAA to 0x12 -> word 4 = 0x11AA3344. Then LB 0x12 -> 0xFFFFFFAA; LBU 0x12 -> 0x000000AA.
- Words 4/5 = 0x44332211 / 0x88776655; LW 0x13 -> stall 1 cycle, then load_data = 0x77665544, split_cnt = 1.
- SH 0xBEEF to 0x17, words 5/6 initially 0 -> word 5 = 0xEF000000, word 6 = 0x000000BE; 2 cycles.
- LW 0xFD (A = 63, split) with MEM_WORDS = 64 -> fault = 1, done = 1, no write. funct3 = 011 load -> fault, load_data = 0.
- Split SW, reset pulsed in SECOND -> state IDLE, split_cnt = 0, word A+1 unchanged, word A updated.
